// File: rtl/branch_resolve_tracker_pkg.sv
// Shared core constants used by the predictor, the pipeline and the branch resolve tracker.
package branch_resolve_tracker_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned PC_INC        = 4;

endpackage

// File: rtl/branch_info_fifo.sv
// Synchronous FIFO for in-flight branch records, with a flush that empties it in one edge.
module branch_info_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_c,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // A push while full is only accepted when the head leaves on the same edge.
  always_comb begin
    do_pop   = pop_i && !empty_q;
    do_push  = push_i && (!full_q || do_pop) && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/branch_resolve_tracker.sv
// Tracks predicted branches from decode to memory stage; reports outcomes and redirects on mispredict.
module branch_resolve_tracker
  import branch_resolve_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dec_valid,
  input  logic [XLEN-1:0] dec_pc,
  input  logic            dec_prediction,
  input  logic [XLEN-1:0] dec_target,
  input  logic            res_valid,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  output logic            full,
  output logic            empty,
  output logic            branch_mem_sig,
  output logic            actual_branch_decision,
  output logic [XLEN-1:0] update_branch_addr,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic            underflow_err
);

  localparam int unsigned ENTRY_W = 2 * XLEN + 1;

  logic [ENTRY_W-1:0] head_c;
  logic [XLEN-1:0]    head_pc, head_tgt;
  logic               head_pred;
  logic               pop, wrong, flush;

  logic            bms_q, mis_q, adec_q, uf_q;
  logic [XLEN-1:0] uba_q, rpc_q;

  assign head_pc   = head_c[ENTRY_W-1 -: XLEN];
  assign head_pred = head_c[XLEN];
  assign head_tgt  = head_c[XLEN-1:0];

  assign pop   = res_valid && !empty;
  assign wrong = (res_taken != head_pred) || (res_taken && (res_target != head_tgt));
  assign flush = pop && wrong;

  branch_info_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (dec_valid),
    .pop_i   (res_valid),
    .wdata_i ({dec_pc, dec_prediction, dec_target}),
    .head_c  (head_c),
    .full_o  (full),
    .empty_o (empty)
  );

  // Outcome and redirect registers; strobes last one cycle, payloads hold until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bms_q  <= 1'b0;
      mis_q  <= 1'b0;
      adec_q <= 1'b0;
      uba_q  <= '0;
      rpc_q  <= '0;
      uf_q   <= 1'b0;
    end else begin
      bms_q <= pop;
      mis_q <= flush;
      if (pop) begin
        adec_q <= res_taken;
        uba_q  <= head_pc;
        rpc_q  <= res_taken ? res_target : head_pc + XLEN'(PC_INC);
      end
      if (res_valid && empty) uf_q <= 1'b1;
    end
  end

  assign branch_mem_sig         = bms_q;
  assign mispredict             = mis_q;
  assign actual_branch_decision = adec_q;
  assign update_branch_addr     = uba_q;
  assign redirect_pc            = rpc_q;
  assign underflow_err          = uf_q;

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Directed plus random bench for branch_resolve_tracker against a queue-based reference model.
module tb_branch_resolve_tracker;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic            clk;
  logic            rst_n;
  logic            dec_valid;
  logic [XLEN-1:0] dec_pc;
  logic            dec_prediction;
  logic [XLEN-1:0] dec_target;
  logic            res_valid;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            full, empty, branch_mem_sig, actual_branch_decision, mispredict, underflow_err;
  logic [XLEN-1:0] update_branch_addr, redirect_pc;

  branch_resolve_tracker #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .dec_valid              (dec_valid),
    .dec_pc                 (dec_pc),
    .dec_prediction         (dec_prediction),
    .dec_target             (dec_target),
    .res_valid              (res_valid),
    .res_taken              (res_taken),
    .res_target             (res_target),
    .full                   (full),
    .empty                  (empty),
    .branch_mem_sig         (branch_mem_sig),
    .actual_branch_decision (actual_branch_decision),
    .update_branch_addr     (update_branch_addr),
    .mispredict             (mispredict),
    .redirect_pc            (redirect_pc),
    .underflow_err          (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic            pred;
    logic [XLEN-1:0] tgt;
  } ent_t;

  ent_t            q[$];
  logic            m_uf, e_bms, e_mis, e_adec;
  logic [XLEN-1:0] e_uba, e_rpc;
  int              errors = 0;
  int              checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("branch_mem_sig", 64'(branch_mem_sig), 64'(e_bms));
    chk("mispredict", 64'(mispredict), 64'(e_mis));
    chk("underflow_err", 64'(underflow_err), 64'(m_uf));
    if (e_bms) begin
      chk("actual_branch_decision", 64'(actual_branch_decision), 64'(e_adec));
      chk("update_branch_addr", 64'(update_branch_addr), 64'(e_uba));
    end
    if (e_mis) chk("redirect_pc", 64'(redirect_pc), 64'(e_rpc));
  endtask

  task automatic model_reset();
    q.delete();
    m_uf   = 1'b0;
    e_bms  = 1'b0;
    e_mis  = 1'b0;
    e_adec = 1'b0;
    e_uba  = '0;
    e_rpc  = '0;
  endtask

  // One clock: drive, let the edge happen, advance the model on the pre-edge state, check.
  task automatic step(input logic dv, input logic [XLEN-1:0] dpc, input logic dpr,
                      input logic [XLEN-1:0] dtg, input logic rv, input logic rtk,
                      input logic [XLEN-1:0] rtg);
    ent_t n, h;
    int   sz;
    logic popped, wrong;
    dec_valid = dv; dec_pc = dpc; dec_prediction = dpr; dec_target = dtg;
    res_valid = rv; res_taken = rtk; res_target = rtg;
    @(posedge clk);
    sz     = q.size();
    popped = rv && (sz > 0);
    wrong  = 1'b0;
    e_bms  = popped;
    if (popped) begin
      h      = q.pop_front();
      wrong  = (rtk != h.pred) || (rtk && (rtg != h.tgt));
      e_adec = rtk;
      e_uba  = h.pc;
      e_rpc  = rtk ? rtg : h.pc + 32'd4;
      if (wrong) q.delete();
    end
    e_mis = wrong;
    if (rv && sz == 0) m_uf = 1'b1;
    if (dv && !wrong && (sz < DEPTH || popped)) begin
      n.pc = dpc; n.pred = dpr; n.tgt = dtg;
      q.push_back(n);
    end
    #1;
    check_all();
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic pr, input logic [XLEN-1:0] tg);
    step(1'b1, pc, pr, tg, 1'b0, 1'b0, '0);
  endtask

  task automatic resolve(input logic tk, input logic [XLEN-1:0] tg);
    step(1'b0, '0, 1'b0, '0, 1'b1, tk, tg);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic            dv, pr, rv, tk;
    logic [XLEN-1:0] pc, tg, rt;
    rst_n = 1'b0;
    dec_valid = 1'b0; dec_pc = '0; dec_prediction = 1'b0; dec_target = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    model_reset();
    #12;
    check_all();
    chk("reset_redirect_pc", 64'(redirect_pc), 64'h0);
    chk("reset_update_addr", 64'(update_branch_addr), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Correct taken prediction.
    push(32'h10, 1'b1, 32'h40);
    resolve(1'b1, 32'h40);
    idle();
    // Predicted taken, actually not taken.
    push(32'h20, 1'b1, 32'h60);
    resolve(1'b0, 32'h0);
    idle();
    // Target mismatch with younger wrong-path entries.
    push(32'h30, 1'b1, 32'h80);
    push(32'h34, 1'b0, 32'h0);
    push(32'h38, 1'b1, 32'h100);
    resolve(1'b1, 32'h90);
    idle();
    // Fill past capacity, then push and pop together while full.
    for (int i = 0; i < DEPTH + 1; i++) push(32'h200 + 32'(i * 4), 1'b0, 32'h0);
    step(1'b1, 32'h300, 1'b1, 32'h400, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) resolve(q.size() > 0 ? q[0].pred : 1'b0,
                                            q.size() > 0 ? q[0].tgt : 32'h0);
    // Mispredict on a same-edge push discards the push; PC+4 wraps.
    push(32'hFFFF_FFFC, 1'b1, 32'h8);
    step(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    // Resolve while empty.
    resolve(1'b1, 32'h44);
    idle();
    // Asynchronous reset with three entries in flight.
    push(32'h600, 1'b0, 32'h0);
    push(32'h604, 1'b1, 32'h700);
    push(32'h608, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("reset_redirect_pc", 64'(redirect_pc), 64'h0);
    chk("reset_update_addr", 64'(update_branch_addr), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    push(32'h800, 1'b1, 32'h900);
    resolve(1'b1, 32'h900);

    // Random traffic, biased so most resolutions match the predicted head.
    for (int i = 0; i < 600; i++) begin
      dv = ($urandom_range(0, 99) < 60);
      rv = ($urandom_range(0, 99) < 45);
      pc = 32'($urandom_range(0, 1023)) << 2;
      pr = 1'($urandom_range(0, 1));
      tg = 32'($urandom_range(0, 1023)) << 2;
      tk = 1'($urandom_range(0, 1));
      rt = 32'($urandom_range(0, 1023)) << 2;
      if (q.size() > 0 && $urandom_range(0, 99) < 80) begin
        tk = q[0].pred;
        rt = q[0].pred ? q[0].tgt : rt;
      end
      step(dv, pc, pr, tg, rv, tk, rt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
